// File: rtl/sync_time_loader.sv
// sync_time_loader
//   Walks channels 0..DEPTH-1 after a START pulse. For each channel it
//   snapshots a future system time (SYS_TIME + LAT) and computes its
//   remainder modulo the channel period on one shared bit-serial unit. It
//   then issues a one-cycle load so that the channel's free-running counter
//   is phase-aligned with SYS_TIME.
//
// Ports
//   CLK       system clock, rising edge
//   RST_N     asynchronous active-low reset
//   START     request a full resync pass (only honoured in IDLE)
//   SYS_TIME  64-bit system time, +1 per CLK
//   CYCLE     per-channel period, DEPTH entries of WIDTH bits
//   BUSY      pass in progress (LATCH/DIV/LOAD)
//   DONE      one-cycle pulse in the FIN cycle
//   LOAD_EN   one-cycle load strobe
//   LOAD_IDX  channel being loaded (valid with LOAD_EN)
//   LOAD_VAL  phase value to load (valid with LOAD_EN)
//   ERR       sticky: a channel in this pass had CYCLE == 0
//
// State  | meaning
// IDLE   | waiting for START
// LATCH  | snapshot SYS_TIME + LAT and CYCLE[idx]
// DIV    | 64 restoring-remainder steps, MSB first
// LOAD   | LOAD_EN high, advance to next channel or finish
// FIN    | DONE pulse, back to IDLE
module sync_time_loader #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        START,
  input  logic [63:0]                 SYS_TIME,
  input  logic [DEPTH-1:0][WIDTH-1:0] CYCLE,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        LOAD_EN,
  output logic [IDX_W-1:0]            LOAD_IDX,
  output logic [WIDTH-1:0]            LOAD_VAL,
  output logic                        ERR
);

  // LATCH -> LOAD is 65 cycles, so the value loaded must be the phase one
  // cycle past the LOAD cycle: 66 cycles past the snapshot.
  localparam int LAT = 66;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_DIV,
    ST_LOAD,
    ST_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0]      x_q, x_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [5:0]       bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_en_q, load_en_d;
  logic [IDX_W-1:0] load_idx_q, load_idx_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_diff;
  logic [WIDTH-1:0] r_next;

  // One restoring step. r < d always holds for d != 0, so the result fits
  // in WIDTH bits; for d == 0 the value is meaningless and masked on load.
  always_comb begin
    r_shift = {r_q, x_q[bit_q]};
    r_diff  = r_shift - {1'b0, d_q};
    r_next  = (r_shift >= {1'b0, d_q}) ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    x_d        = x_q;
    d_d        = d_q;
    r_d        = r_q;
    bit_d      = bit_q;
    done_d     = 1'b0;
    load_en_d  = 1'b0;
    load_idx_d = load_idx_q;
    load_val_d = load_val_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        x_d     = SYS_TIME + 64'(LAT);
        d_d     = CYCLE[idx_q];
        r_d     = '0;
        bit_d   = 6'd63;
        state_d = ST_DIV;
      end
      ST_DIV: begin
        r_d   = r_next;
        bit_d = bit_q - 6'd1;
        // Outputs are registered, so the load strobe and its data are set
        // up on the final step to appear in the LOAD cycle itself.
        if (bit_q == 6'd0) begin
          state_d    = ST_LOAD;
          load_en_d  = 1'b1;
          load_idx_d = idx_q;
          load_val_d = (d_q == '0) ? '0 : r_next;
          if (d_q == '0) begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_LATCH;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_LATCH) || (state_d == ST_DIV) || (state_d == ST_LOAD);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      x_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      bit_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_en_q  <= 1'b0;
      load_idx_q <= '0;
      load_val_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      d_q        <= d_d;
      r_q        <= r_d;
      bit_q      <= bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_en_q  <= load_en_d;
      load_idx_q <= load_idx_d;
      load_val_q <= load_val_d;
      err_q      <= err_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign LOAD_EN  = load_en_q;
  assign LOAD_IDX = load_idx_q;
  assign LOAD_VAL = load_val_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_sync_time_loader.sv
// Bench for sync_time_loader: the stimulus side pushes the expected loads
// and DONE of each pass (computed with plain modulo arithmetic on the
// channel target times) into queues; a negedge monitor pops and compares.
module tb_sync_time_loader;
  localparam int WIDTH = 13;
  localparam int DEPTH = 249;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PER   = 66;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [63:0] sys_time = '0;
  logic [63:0] jump_val = '0;
  logic jump_req = 1'b0;
  logic [DEPTH-1:0][WIDTH-1:0] cyc_in;

  logic             busy, done, load_en, err;
  logic [IDX_W-1:0] load_idx;
  logic [WIDTH-1:0] load_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [63:0] val;
    logic [63:0] t;
    logic        err;
  } exp_t;

  exp_t load_q[$];
  exp_t done_q[$];

  sync_time_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .SYS_TIME(sys_time),
    .CYCLE(cyc_in), .BUSY(busy), .DONE(done), .LOAD_EN(load_en),
    .LOAD_IDX(load_idx), .LOAD_VAL(load_val), .ERR(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sys_time <= jump_req ? jump_val : sys_time + 64'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: channel k is loaded when SYS_TIME = s0+66+66k and its value
  // is the phase one cycle later, (s0+67+66k) mod CYCLE[k].
  task automatic push_model(input logic [63:0] s0);
    logic [63:0] tgt;
    logic [63:0] c;
    logic e;
    exp_t x;
    e = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      c   = 64'(cyc_in[k]);
      tgt = s0 + 64'd1 + 64'(PER) * 64'(k + 1);
      if (c == 0) e = 1'b1;
      x.idx = k;
      x.val = (c == 0) ? 64'd0 : tgt % c;
      x.t   = s0 + 64'(PER) * 64'(k + 1);
      x.err = e;
      load_q.push_back(x);
    end
    x.idx = 0;
    x.val = 0;
    x.t   = s0 + 64'(PER) * 64'(DEPTH) + 64'd1;
    x.err = e;
    done_q.push_back(x);
  endtask

  // Monitor
  logic prev_load_en = 1'b0;
  int loads_seen = 0;
  int dones_seen = 0;
  logic [63:0] first_val = '0;
  logic [63:0] first_time = '0;
  logic [63:0] last_val = '0;
  logic [63:0] last_time = '0;
  exp_t me;

  always @(negedge clk) begin
    if (load_en) begin
      loads_seen++;
      check("load_back_to_back", 64'(prev_load_en), 64'd0);
      check("busy_at_load", 64'(busy), 64'd1);
      if (load_q.size() == 0) begin
        check("unexpected_load_idx", 64'(load_idx), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        me = load_q.pop_front();
        check("load_idx", 64'(load_idx), 64'(me.idx));
        check("load_val", 64'(load_val), me.val);
        check("load_time", sys_time, me.t);
        check("err_at_load", 64'(err), 64'(me.err));
      end
      if (load_idx == '0) begin
        first_val  = 64'(load_val);
        first_time = sys_time;
      end
      last_val  = 64'(load_val);
      last_time = sys_time;
    end
    if (load_q.size() > 0 && longint'(sys_time - load_q[0].t) > 0) begin
      me = load_q.pop_front();
      check("missing_load_time", sys_time, me.t);
    end
    if (done) begin
      dones_seen++;
      check("busy_with_done", 64'(busy), 64'd0);
      if (done_q.size() == 0) begin
        check("unexpected_done_time", sys_time, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        me = done_q.pop_front();
        check("done_time", sys_time, me.t);
        check("err_at_done", 64'(err), 64'(me.err));
      end
    end
    if (done_q.size() > 0 && longint'(sys_time - done_q[0].t) > 0) begin
      me = done_q.pop_front();
      check("missing_done_time", sys_time, me.t);
    end
    prev_load_en = load_en;
  end

  task automatic fill(input logic [WIDTH-1:0] c);
    for (int i = 0; i < DEPTH; i++) cyc_in[i] = c;
  endtask

  task automatic wait_until(input logic [63:0] t);
    int n = 0;
    while (sys_time != t && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sys_time != t) check("wait_until_timeout", sys_time, t);
  endtask

  task automatic wait_done(input int limit);
    int n0 = dones_seen;
    int n = 0;
    while (dones_seen == n0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (dones_seen == n0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic start_pass(input logic [63:0] s0);
    jump_val = s0;
    jump_req = 1'b1;
    @(posedge clk); #1;
    jump_req = 1'b0;
    push_model(s0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_cleared_on_start", 64'(err), 64'd0);
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {57'd0, busy, done, load_en, err, |load_idx, |load_val}, 64'd0);
    load_q.delete();
    done_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s0;
    int n0;
    fill(13'd4000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_initial", {58'd0, busy, done, load_en, err, |load_idx, |load_val}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic pass, with a START pulse mid-pass and one in the FIN cycle
    start_pass(64'd1000);
    wait_until(64'd6000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_until(64'd1000 + 64'(PER * DEPTH) + 64'd1);
    check("basic_done_in_fin", 64'(done), 64'd1);
    check("basic_err", 64'(err), 64'd0);
    check("basic_ch0_val", first_val, 64'd1067);
    check("basic_ch0_time", first_time, 64'd1066);
    check("basic_last_val", last_val, 64'd1435);
    check("basic_last_time", last_time, 64'd17434);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      check("start_in_fin_ignored", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end

    // Mixed periods
    for (int i = 0; i < DEPTH; i++) cyc_in[i] = WIDTH'(i + 1);
    start_pass(64'd123456789);
    wait_done(PER * DEPTH + 20);
    check("mixed_ch0_val", first_val, 64'd0);
    @(posedge clk); #1;

    // Zero period on channel 5
    fill(13'd4000);
    cyc_in[5] = '0;
    start_pass(64'd5000);
    wait_done(PER * DEPTH + 20);
    @(posedge clk); #1;
    check("zero_err_held", 64'(err), 64'd1);

    // Overflow; also confirms the new START clears ERR
    fill(13'd4000);
    start_pass(64'hFFFF_FFFF_FFFF_FFF6);
    wait_until(64'hFFFF_FFFF_FFFF_FFF6 + 64'd70);
    check("overflow_ch0_val", first_val, 64'd57);
    do_reset();

    // Random passes, first two channels each, with CYCLE toggled during DIV
    for (int p = 0; p < 100; p++) begin
      if (p % 2 == 0) fill(13'd8191);
      else for (int i = 0; i < DEPTH; i++) cyc_in[i] = WIDTH'($urandom_range(0, 8191));
      s0 = {$urandom, $urandom};
      start_pass(s0);
      wait_until(s0 + 64'd20);
      cyc_in[0] = ~cyc_in[0];
      wait_until(s0 + 64'd90);
      cyc_in[1] = ~cyc_in[1];
      wait_until(s0 + 64'd133);
      do_reset();
      @(posedge clk); #1;
    end

    // Reset during DIV of channel 100
    for (int i = 0; i < DEPTH; i++) cyc_in[i] = WIDTH'($urandom_range(1, 8191));
    s0 = {$urandom, $urandom};
    n0 = loads_seen;
    start_pass(s0);
    wait_until(s0 + 64'd1 + 64'(PER * 100) + 64'd30);
    check("loads_before_reset", 64'(loads_seen - n0), 64'd100);
    do_reset();
    n0 = loads_seen;
    repeat (200) @(posedge clk);
    #1;
    check("no_load_after_reset", 64'(loads_seen - n0), 64'd0);
    s0 = {$urandom, $urandom};
    start_pass(s0);
    wait_until(s0 + 64'd70);
    check("restart_first_loads", 64'(loads_seen - n0), 64'd1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_time_loader.md
# sync_time_loader

Resynchronizes the per-transducer free-running time counters to the 64-bit system time. After a START pulse it visits channels 0..DEPTH-1 in order. For each channel it computes the phase (future SYS_TIME) mod CYCLE[i] on a single shared bit-serial remainder unit, then issues a one-cycle load so that the channel's counter is phase-aligned with SYS_TIME. It sits between the system-time source and the per-channel time-count generator, whose counters accept LOAD_EN/LOAD_IDX/LOAD_VAL.

## Interface
Parameters:
- WIDTH, 13, width of CYCLE and of the counter values
- DEPTH, 249, number of channels
- IDX_W, $clog2(DEPTH), channel index width

Localparam:
- LAT = 66, fixed snapshot-to-target offset

Ports:
- CLK  in  1  single system clock; all logic on its rising edge
- RST_N  in  1  reset, asynchronous and active-low
- START  in  1  request a full resync pass; sampled only in IDLE
- SYS_TIME  in  64  system time; increments by 1 every CLK
- CYCLE  in  [WIDTH-1:0] x DEPTH  per-channel period
- BUSY  out  1  high while a pass is in progress
- DONE  out  1  one-cycle pulse when a pass completes
- LOAD_EN  out  1  one-cycle load strobe
- LOAD_IDX  out  IDX_W  channel to load; valid while LOAD_EN is high
- LOAD_VAL  out  WIDTH  value to load; valid while LOAD_EN is high
- ERR  out  1  sticky flag: some channel in this pass had CYCLE == 0

## Operation
- States: IDLE, LATCH, DIV, LOAD, FIN.
- IDLE:
  - START=1 → clear ERR, idx←0, go to LATCH.
  - START=1 is ignored in every other state.
- LATCH (1 cycle):
  - X ← SYS_TIME + LAT, a 64-bit sum that wraps modulo 2^64.
  - d ← CYCLE[idx], r ← 0, bit counter ← 63.
  - Go to DIV.
- DIV (64 cycles, restoring remainder, MSB first):
  - r' = {r, X[b]}, computed in WIDTH+1 bits.
  - r ← (r' ≥ d) ? r' − d : r'.
  - b decrements each cycle; after b=0, go to LOAD.
- LOAD (1 cycle):
  - LOAD_EN=1, LOAD_IDX=idx.
  - LOAD_VAL = r[WIDTH-1:0], or 0 if d==0. When d==0, set ERR.
  - If idx==DEPTH-1, go to FIN. Otherwise idx←idx+1 and go to LATCH.
- FIN (1 cycle): DONE=1, then go to IDLE.
- Alignment invariant: if LOAD_EN is high in the cycle where SYS_TIME=S, then LOAD_VAL = (S+1) mod CYCLE[idx].
  - Reason: LOAD occurs exactly 65 cycles after LATCH, and S+1 = SYS_TIME_at_LATCH + 66.
- Sampling rules:
  - CYCLE[idx] is sampled only in LATCH. Changes during DIV do not affect the current channel.
  - CYCLE==1 yields 0 naturally; no special case is needed.
- BUSY is high in LATCH, DIV and LOAD; low in IDLE and FIN.
- The ERR flag holds until the next accepted START or until reset.

## Timing
- All outputs are registered.
- Reset values: BUSY=0, DONE=0, LOAD_EN=0, LOAD_IDX=0, LOAD_VAL=0, ERR=0; state=IDLE.
- RST_N low at any point, including mid-pass:
  - Outputs go to reset values immediately.
  - No further LOAD_EN is issued.
  - A later START begins again at channel 0.
- START accepted in cycle t:
  - LATCH of channel k occurs in cycle t+1+66k.
  - LOAD of channel k occurs in cycle t+66+66k.
  - DONE occurs in cycle t+66·DEPTH+1.
- Per channel: 66 cycles. Full pass at DEPTH=249: 16434 cycles from LATCH of channel 0 to the last LOAD.
- LOAD_EN is never high in two consecutive cycles. LOAD_IDX increases strictly by 1 across a pass.
- Wrap-around: when SYS_TIME + LAT overflows 2^64, the wrapped X is used. The resulting phase discontinuity is accepted.
- DONE and BUSY are never high in the same cycle.
- START asserted in the FIN cycle is ignored. It is accepted from the following IDLE cycle.

## Test plan
- Basic pass: all CYCLE=4000; SYS_TIME starts at 0 at reset release; START high in the cycle SYS_TIME=1000.
  - Required: channel-0 LOAD at SYS_TIME=1066 with LOAD_VAL=1067.
  - Required: channel-248 LOAD at SYS_TIME=17434 with LOAD_VAL=(17435 mod 4000)=1435.
  - Required: DONE at SYS_TIME=17435; ERR=0.
- Mixed periods: CYCLE[i]=i+1; START at SYS_TIME=123456789.
  - Required: every LOAD_VAL == (S+1) mod (i+1) against a reference model.
  - Required: channel 0 loads 0.
- Zero period: CYCLE[5]=0, all others 4000.
  - Required: channel 5 loads 0 and ERR rises at that LOAD and stays high through DONE.
  - Required: the next START clears ERR.
- Overflow: SYS_TIME driven to 2^64−10 when START is accepted; CYCLE=4000.
  - Required: channel 0 LOAD_VAL = ((2^64−10+1+66) mod 2^64) mod 4000 = 57.
- Random data: 100 random 64-bit SYS_TIME starts with CYCLE=8191 and random CYCLE arrays.
  - Required: all LOAD_VAL values match the model.
  - Required: CYCLE[idx] toggled during DIV has no effect on the current channel.
- Control robustness:
  - START pulsed during BUSY → ignored; pass length unchanged.
  - RST_N pulled low during DIV of channel 100 → all outputs 0 immediately, no LOAD_EN afterwards.
  - A new START after reset → first LOAD_IDX=0.
